// File: rtl/ram_rd_checker_pkg.sv
// rtl/ram_rd_checker_pkg.sv - shared state encoding and URAM geometry defaults
package ram_rd_checker_pkg;

    // Sweep sequencer states, shared with the write-pattern controller
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int DEF_DATA_WIDTH = 72;
    localparam int DEF_DATA_DEPTH = 4096;
    localparam int DEF_RD_LATENCY = 2;

    // Address width for a given depth; never collapses to zero bits
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_delay_line.sv
// rtl/ram_rd_delay_line.sv - DEPTH-deep {valid, addr} shift register with synchronous flush
module ram_rd_delay_line #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    // Shift valid/addr one stage per cycle; flush drops every in-flight valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= valid_i;
                for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
            end
            addr_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) addr_q[i] <= addr_q[i-1];
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/ram_rd_checker.sv
// rtl/ram_rd_checker.sv - URAM port-B sweep that checks the incrementing write pattern
module ram_rd_checker
    import ram_rd_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int ERR_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [DATA_WIDTH-1:0]            exp_base,
    output logic [addr_w(DATA_DEPTH)-1:0]    addrb,
    output logic                             enb,
    input  logic [DATA_WIDTH-1:0]            doutb,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [ERR_W-1:0]                 err_cnt,
    output logic [addr_w(DATA_DEPTH)-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]            first_err_data
);

    localparam int              AW       = addr_w(DATA_DEPTH);
    localparam logic [AW-1:0]   LAST_A   = AW'(DATA_DEPTH - 1);
    localparam logic [2:0]      LAST_DRN = 3'(RD_LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    rd_state_e              state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [2:0]             drain_q, drain_d;
    logic [DATA_WIDTH-1:0]  base_q, base_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   pass_q, pass_d;
    logic                   ferr_q, ferr_d;
    logic [AW-1:0]          faddr_q, faddr_d;
    logic [DATA_WIDTH-1:0]  fdata_q, fdata_d;
    logic                   flush;
    logic                   pipe_valid;
    logic [AW-1:0]          pipe_addr;
    logic                   mismatch;

    ram_rd_delay_line #(
        .DEPTH  (RD_LATENCY),
        .ADDR_W (AW)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .valid_i (enb),
        .addr_i  (addr_q),
        .valid_o (pipe_valid),
        .addr_o  (pipe_addr)
    );

    // Word returned for pipe_addr must equal base + addr, wrapping at DATA_WIDTH bits
    assign mismatch = pipe_valid && (doutb != (base_q + DATA_WIDTH'(pipe_addr)));

    // Next-state, error accounting and start/abort handling
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        base_d  = base_q;
        err_d   = err_q;
        pass_d  = pass_q;
        ferr_d  = ferr_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        flush   = 1'b0;

        if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!ferr_q) begin
                ferr_d  = 1'b1;
                faddr_d = pipe_addr;
                fdata_d = doutb;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    base_d  = exp_base;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    ferr_d  = 1'b0;
                    faddr_d = '0;
                    fdata_d = '0;
                    flush   = 1'b1;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else if (addr_q == LAST_A) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else if (drain_q == LAST_DRN) begin
                    // Final compare lands this cycle, so judge on the updated count
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            base_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            ferr_q  <= 1'b0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            base_q  <= base_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            ferr_q  <= ferr_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    assign addrb          = addr_q;
    assign enb            = (state_q == ST_READ);
    assign busy           = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = faddr_q;
    assign first_err_data = fdata_q;

endmodule

// File: doc/ram_rd_checker.md
Name: ram_rd_checker

Overview:
- Read-side companion to the URAM write-pattern controller.
- On command, sweeps port B of the URAM across all DATA_DEPTH addresses and compares each returned word against the incrementing pattern (word at address a = exp_base + a).
- Counts mismatches and captures the first failing address/data.
- Sits beside the URAM top, sharing clk, and reports pass/fail status to the test/control logic.

Parameters:
- DATA_WIDTH, 72, width of a URAM word.
- DATA_DEPTH, 4096, number of words swept; power of two.
- RD_LATENCY, 2, clk cycles from addrb/enb to valid doutb; legal range 1..4.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a sweep; ignored while busy=1.
- abort  in  1  synchronous cancel of a running sweep.
- exp_base  in  DATA_WIDTH  pattern offset; latched on accepted start.
- addrb  out  $clog2(DATA_DEPTH)  URAM port-B read address.
- enb  out  1  URAM port-B read enable.
- doutb  in  DATA_WIDTH  URAM port-B read data, valid RD_LATENCY cycles after enb.
- busy  out  1  sweep in progress (READ or DRAIN).
- done  out  1  one-cycle pulse when a sweep completes normally.
- pass  out  1  1 when the last completed sweep had zero mismatches.
- err_cnt  out  ERR_W  mismatch count of current/last sweep; saturates at all-ones.
- first_err_addr  out  $clog2(DATA_DEPTH)  address of the first mismatch.
- first_err_data  out  DATA_WIDTH  doutb value at the first mismatch.

Behaviour:
- Reset values:
  - All outputs 0 (addrb, enb, busy, done, pass, err_cnt, first_err_*).
  - FSM in IDLE; compare pipeline valid bits 0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 -> READ. On the start cycle: latch exp_base; clear err_cnt, pass, first_err_*, the first-error flag, and the pipeline.
  - READ:
    - enb=1 every cycle; addrb starts at 0 and increments by 1 per cycle.
    - The cycle addrb = DATA_DEPTH-1 is issued -> DRAIN. No wrap is issued.
  - DRAIN: enb=0, addrb holds at DATA_DEPTH-1. After exactly RD_LATENCY cycles (last compare done) -> DONE.
  - DONE: done=1 and pass=(err_cnt==0) for one cycle -> IDLE.
- busy=1 in READ and DRAIN only.
- Sweep length: first enb to done pulse = DATA_DEPTH + RD_LATENCY + 1 cycles.
- Compare pipeline:
  - RD_LATENCY-deep shift register of {valid, addr}, loaded from {enb, addrb}.
  - At the pipeline output, when valid: expected = exp_base_latched + addr, zero-extended, sum modulo 2^DATA_WIDTH. Mismatch when doutb != expected.
- On mismatch:
  - err_cnt += 1, saturating at 2^ERR_W-1.
  - First mismatch only: capture first_err_addr/first_err_data and set the first-error flag. Later mismatches do not overwrite.
- Results (err_cnt, pass, first_err_*) hold after DONE until the next accepted start.
- abort=1 in READ or DRAIN:
  - Next cycle IDLE with enb=0; pipeline valid bits cleared.
  - No done pulse; pass stays 0; err_cnt keeps the partial count.
  - abort in IDLE/DONE has no effect.
- start and abort in the same IDLE cycle: abort wins; start is not accepted.
- start while busy or in DONE: ignored.
- Async reset mid-sweep: immediate return to reset values; no done.

Decomposition:
- Shared package: state encoding (IDLE/READ/DRAIN/DONE), ADDR_W = $clog2(DATA_DEPTH) helper, and defaults for DATA_WIDTH/DATA_DEPTH/RD_LATENCY, so the write controller and checker agree.
- One natural sub-module: ram_rd_delay_line, a parameterised RD_LATENCY-deep {valid, addr} shift register with synchronous flush. It is reused for any other URAM consumer.

Test Plan:
- Clean sweep: URAM model (RD_LATENCY=2) preloaded with mem[a]=a, exp_base=0, pulse start -> enb high 4096 cycles, done at cycle 4099 after first enb, pass=1, err_cnt=0.
- Offset pattern: mem[a]=4096+a, exp_base=4096 -> pass=1. Same memory with exp_base=0 -> err_cnt=4096, first_err_addr=0, first_err_data=4096.
- Single corruption: mem[100] bit 71 flipped -> err_cnt=1, first_err_addr=100, first_err_data=100^(1<<71), pass=0. A second fault at mem[200] -> err_cnt=2, first_err_addr stays 100.
- Saturation: ERR_W=4, all words wrong -> err_cnt=15 at done, pass=0.
- Abort at addrb=50 -> enb=0 next cycle, busy=0, no done pulse, pass=0. A new start then completes normally with pass=1.
- Protocol edges:
  - start pulsed while busy -> ignored.
  - start and abort together in IDLE -> stays IDLE.
  - rst_n low at addrb=1000 -> all outputs 0 immediately.
  - RD_LATENCY=1 and 4 builds -> pass=1 on clean memory.
